// File: rtl/alu_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// alu_sequencer_pkg
//
// Purpose: shared definitions for the ALU sequencer slice. It holds the
// datapath width, the two-bit ALU opcode encodings and the sequencer
// state type. The top level and the ALU both import this package.
//
// Ports: none (package only).
// ---------------------------------------------------------------------------
package alu_sequencer_pkg;

    localparam int DATA_W = 16;

    // Opcode encodings as they appear on the in_op port.
    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_OR  = 2'b11
    } alu_op_e;

    // Sequencer states: accept, compute/writeback, present result.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        HOLD = 2'b10
    } seq_state_e;

endpackage : alu_sequencer_pkg

// File: rtl/alu_sequencer_alu.sv
// ---------------------------------------------------------------------------
// alu_sequencer_alu
//
// Purpose: purely combinational 16-bit ALU used by the sequencer. Add and
// subtract produce a carry out of bit 15. Subtract is formed as
// a + ~b + 1, so a carry of 1 means that no borrow occurred. The logical
// operations always report a carry of 0.
//
// Ports:
//   op     - input  alu_op_e       : operation select
//   a, b   - input  [DATA_W-1:0]   : operands (subtract computes a - b)
//   result - output [DATA_W-1:0]   : result modulo 2^DATA_W
//   cout   - output                : carry out of the top bit
// ---------------------------------------------------------------------------
module alu_sequencer_alu
    import alu_sequencer_pkg::*;
(
    input  alu_op_e           op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result,
    output logic              cout
);

    logic [DATA_W:0] sum;

    always_comb begin
        sum    = '0;
        result = '0;
        cout   = 1'b0;
        case (op)
            OP_ADD: begin
                sum    = {1'b0, a} + {1'b0, b};
                result = sum[DATA_W-1:0];
                cout   = sum[DATA_W];
            end
            OP_SUB: begin
                // The extra bit catches the carry of the two's-complement add.
                sum    = {1'b0, a} + {1'b0, ~b} + {{DATA_W{1'b0}}, 1'b1};
                result = sum[DATA_W-1:0];
                cout   = sum[DATA_W];
            end
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            default: begin
                result = '0;
                cout   = 1'b0;
            end
        endcase
    end

endmodule : alu_sequencer_alu

// File: rtl/alu_sequencer.sv
// ---------------------------------------------------------------------------
// alu_sequencer
//
// Purpose: a three-state sequencer (IDLE -> EXEC -> HOLD) around a small
// register file and a 16-bit ALU.
//   - In IDLE, the sequencer accepts one instruction.
//   - In EXEC, it reads both operands, registers the result and writes the
//     result back to rd.
//   - In HOLD, it presents the result until downstream takes it.
// A direct load port can write the register file in any state. When a load
// and the EXEC writeback target the same index, the writeback wins.
//
// Optional feature: define ALU_SEQUENCER_ZERO_FLAG_EN to register out_zero
// (result == 0) in EXEC. Without the macro, out_zero is tied to 0.
//
// Ports:
//   clk, reset             - clock; synchronous active-high reset
//   in_valid / in_ready    - instruction handshake
//   in_op                  - 00 add, 01 sub, 10 and, 11 or
//   in_rd/in_rs1/in_rs2    - destination / source register indices
//   ld_en/ld_addr/ld_data  - direct register-file load
//   out_valid / out_ready  - result handshake
//   out_data/out_cout      - registered result and carry
//   out_zero               - registered zero flag (optional, see above)
// ---------------------------------------------------------------------------
module alu_sequencer
    import alu_sequencer_pkg::*;
#(
    parameter  int NREGS = 4,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_op,
    input  logic [AW-1:0]     in_rd,
    input  logic [AW-1:0]     in_rs1,
    input  logic [AW-1:0]     in_rs2,
    input  logic              ld_en,
    input  logic [AW-1:0]     ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_cout,
    output logic              out_zero
);

    seq_state_e        state_q, state_d;
    alu_op_e           op_q, op_d;
    logic [AW-1:0]     rd_q, rd_d;
    logic [AW-1:0]     rs1_q, rs1_d;
    logic [AW-1:0]     rs2_q, rs2_d;
    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_cout_q, out_cout_d;
`ifdef ALU_SEQUENCER_ZERO_FLAG_EN
    logic              out_zero_q, out_zero_d;
`endif

    logic [DATA_W-1:0] alu_result;
    logic              alu_cout;

    // The operands come from the register outputs, so an aliased rd always
    // sees the value from before this cycle's writeback.
    alu_sequencer_alu u_alu (
        .op     (op_q),
        .a      (regs_q[rs1_q]),
        .b      (regs_q[rs2_q]),
        .result (alu_result),
        .cout   (alu_cout)
    );

    // Next-state logic. The direct load is applied first, so the EXEC
    // writeback below overrides it when both target the same index.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        rd_d       = rd_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        regs_d     = regs_q;
        out_data_d = out_data_q;
        out_cout_d = out_cout_q;
`ifdef ALU_SEQUENCER_ZERO_FLAG_EN
        out_zero_d = out_zero_q;
`endif
        in_ready   = 1'b0;
        out_valid  = 1'b0;

        if (ld_en) begin
            regs_d[ld_addr] = ld_data;
        end

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    op_d    = alu_op_e'(in_op);
                    rd_d    = in_rd;
                    rs1_d   = in_rs1;
                    rs2_d   = in_rs2;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                out_data_d   = alu_result;
                out_cout_d   = alu_cout;
`ifdef ALU_SEQUENCER_ZERO_FLAG_EN
                out_zero_d   = (alu_result == '0);
`endif
                regs_d[rd_q] = alu_result;
                state_d      = HOLD;
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register. Reset discards any instruction in flight and clears
    // the register file and the output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            op_q       <= OP_ADD;
            rd_q       <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            regs_q     <= '{default: '0};
            out_data_q <= '0;
            out_cout_q <= 1'b0;
`ifdef ALU_SEQUENCER_ZERO_FLAG_EN
            out_zero_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            rd_q       <= rd_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            regs_q     <= regs_d;
            out_data_q <= out_data_d;
            out_cout_q <= out_cout_d;
`ifdef ALU_SEQUENCER_ZERO_FLAG_EN
            out_zero_q <= out_zero_d;
`endif
        end
    end

    assign out_data = out_data_q;
    assign out_cout = out_cout_q;
`ifdef ALU_SEQUENCER_ZERO_FLAG_EN
    assign out_zero = out_zero_q;
`else
    assign out_zero = 1'b0;
`endif

endmodule : alu_sequencer

// File: tb/tb_alu_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_sequencer
//
// Purpose: self-checking bench for alu_sequencer. The stimulus process
// keeps a plain array model of the register file. At each instruction
// accept, it pushes the expected result into a queue. A monitor process
// pops and compares that entry on every output handshake. Build with
// ALU_SEQUENCER_ZERO_FLAG_EN defined to also check the zero flag.
// ---------------------------------------------------------------------------
module tb_alu_sequencer;

    localparam int NREGS = 4;
    localparam int AW    = 2;

    typedef struct {
        logic [15:0] data;
        logic        cout;
        logic        zero;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [AW-1:0] in_rd, in_rs1, in_rs2;
    logic        ld_en;
    logic [AW-1:0] ld_addr;
    logic [15:0] ld_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_cout;
    logic        out_zero;

    int          checks = 0;
    int          errors = 0;
    exp_t        exp_q[$];
    logic [15:0] model_regs [NREGS];

    alu_sequencer #(.NREGS(NREGS)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .ld_en     (ld_en),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_cout  (out_cout),
        .out_zero  (out_zero)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    // Compare one observed value against its expected value and log mismatches.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Reference ALU written directly as unsigned arithmetic on integers.
    function automatic exp_t ref_alu(input logic [1:0] op, input logic [15:0] a,
                                     input logic [15:0] b);
        exp_t        e;
        int unsigned ia = a;
        int unsigned ib = b;
        int unsigned r;
        e.cout = 1'b0;
        case (op)
            2'd0: begin
                r      = ia + ib;
                e.cout = (r >= 65536);
                r      = r % 65536;
            end
            2'd1: begin
                e.cout = (ia >= ib);
                r      = (ia + 65536 - ib) % 65536;
            end
            2'd2: r = ia & ib;
            default: r = ia | ib;
        endcase
        e.data = r[15:0];
`ifdef ALU_SEQUENCER_ZERO_FLAG_EN
        e.zero = (r == 0);
`else
        e.zero = 1'b0;
`endif
        return e;
    endfunction

    // Monitor: every output handshake must match the oldest pending expectation.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_output", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                checkOutput("out_data", {16'd0, out_data}, {16'd0, e.data});
                checkOutput("out_cout", {31'd0, out_cout}, {31'd0, e.cout});
                checkOutput("out_zero", {31'd0, out_zero}, {31'd0, e.zero});
            end
        end
    end

    // Drive a single direct load while the sequencer is idle.
    task automatic loadReg(input int addr, input logic [15:0] data);
        ld_en   = 1'b1;
        ld_addr = AW'(addr);
        ld_data = data;
        @(posedge clk); #1;
        ld_en = 1'b0;
        model_regs[addr] = data;
    endtask

    // Run one full instruction.
    //   - acc_ld: a load in the accept cycle.
    //   - exec_ld: a load during EXEC.
    //   - stall: the number of HOLD cycles with out_ready low.
    // Entry and exit are both #1 after a rising edge, with the DUT in IDLE.
    task automatic applyStimulus(input logic [1:0] op, input int rd, input int rs1,
                                 input int rs2, input bit acc_ld, input int acc_addr,
                                 input logic [15:0] acc_data, input bit exec_ld,
                                 input int exec_addr, input logic [15:0] exec_data,
                                 input int stall);
        exp_t e;
        checkOutput("idle_in_ready", {31'd0, in_ready}, 32'd1);
        if (acc_ld) begin
            ld_en   = 1'b1;
            ld_addr = AW'(acc_addr);
            ld_data = acc_data;
            model_regs[acc_addr] = acc_data;
        end
        in_valid = 1'b1;
        in_op    = op;
        in_rd    = AW'(rd);
        in_rs1   = AW'(rs1);
        in_rs2   = AW'(rs2);
        e = ref_alu(op, model_regs[rs1], model_regs[rs2]);
        model_regs[rd] = e.data;
        exp_q.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
        ld_en    = 1'b0;
        checkOutput("exec_in_ready", {31'd0, in_ready}, 32'd0);
        checkOutput("exec_out_valid", {31'd0, out_valid}, 32'd0);
        if (exec_ld) begin
            ld_en   = 1'b1;
            ld_addr = AW'(exec_addr);
            ld_data = exec_data;
            if (exec_addr != rd) model_regs[exec_addr] = exec_data;
        end
        @(posedge clk); #1;
        ld_en = 1'b0;
        checkOutput("latency_out_valid", {31'd0, out_valid}, 32'd1);
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'b1;
            in_op    = 2'($urandom_range(0, 3));
            in_rd    = AW'($urandom_range(0, NREGS - 1));
            in_rs1   = AW'($urandom_range(0, NREGS - 1));
            in_rs2   = AW'($urandom_range(0, NREGS - 1));
            @(posedge clk); #1;
            checkOutput("hold_in_ready", {31'd0, in_ready}, 32'd0);
            checkOutput("hold_out_valid", {31'd0, out_valid}, 32'd1);
            checkOutput("hold_out_data", {16'd0, out_data}, {16'd0, e.data});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checkOutput("back_idle_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("back_idle_out_valid", {31'd0, out_valid}, 32'd0);
    endtask

    // Accept an instruction, then assert reset during its EXEC cycle.
    task automatic resetInExec(input logic [1:0] op, input int rd, input int rs1,
                               input int rs2);
        in_valid = 1'b1;
        in_op    = op;
        in_rd    = AW'(rd);
        in_rs1   = AW'(rs1);
        in_rs2   = AW'(rs2);
        @(posedge clk); #1;
        in_valid = 1'b0;
        reset    = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < NREGS; i++) model_regs[i] = 16'h0000;
        checkOutput("rst_exec_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("rst_exec_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rst_exec_out_data", {16'd0, out_data}, 32'd0);
        @(posedge clk); #1;
        checkOutput("rst_exec_no_hold", {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_op     = 2'd0;
        in_rd     = '0;
        in_rs1    = '0;
        in_rs2    = '0;
        ld_en     = 1'b0;
        ld_addr   = '0;
        ld_data   = 16'h0000;
        out_ready = 1'b0;
        for (int i = 0; i < NREGS; i++) model_regs[i] = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        checkOutput("reset_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("reset_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("reset_out_data", {16'd0, out_data}, 32'd0);
        checkOutput("reset_out_cout", {31'd0, out_cout}, 32'd0);
        checkOutput("reset_out_zero", {31'd0, out_zero}, 32'd0);

        // Read every register through OR r,r to confirm that reset cleared it.
        for (int r = 0; r < NREGS; r++)
            applyStimulus(2'd3, r, r, r, 0, 0, 16'h0, 0, 0, 16'h0, 0);

        // SUB 5 - 3 into r2, then read r2 back.
        loadReg(0, 16'h0005);
        loadReg(1, 16'h0003);
        applyStimulus(2'd1, 2, 0, 1, 0, 0, 16'h0, 0, 0, 16'h0, 0);
        applyStimulus(2'd3, 3, 2, 2, 0, 0, 16'h0, 0, 0, 16'h0, 0);

        // ADD wraps to zero with carry out.
        loadReg(0, 16'hFFFF);
        loadReg(1, 16'h0001);
        applyStimulus(2'd0, 2, 0, 1, 0, 0, 16'h0, 0, 0, 16'h0, 0);

        // SUB with borrow, then AND and OR, with a 3-cycle stall in HOLD.
        loadReg(0, 16'h0003);
        loadReg(1, 16'h0005);
        applyStimulus(2'd1, 2, 0, 1, 0, 0, 16'h0, 0, 0, 16'h0, 3);
        loadReg(0, 16'h0F0F);
        loadReg(1, 16'h00FF);
        applyStimulus(2'd2, 2, 0, 1, 0, 0, 16'h0, 0, 0, 16'h0, 0);
        applyStimulus(2'd3, 3, 0, 1, 0, 0, 16'h0, 0, 0, 16'h0, 0);

        // A load during EXEC to rd loses to the writeback; read rd back.
        applyStimulus(2'd0, 2, 0, 1, 0, 0, 16'h0, 1, 2, 16'hBEEF, 0);
        applyStimulus(2'd3, 3, 2, 2, 0, 0, 16'h0, 0, 0, 16'h0, 0);

        // A load in the accept cycle is seen by that instruction's operand read.
        applyStimulus(2'd0, 3, 1, 0, 1, 1, 16'h1234, 0, 0, 16'h0, 0);

        // Fully aliased operands and destination.
        applyStimulus(2'd0, 0, 0, 0, 0, 0, 16'h0, 0, 0, 16'h0, 0);
        applyStimulus(2'd3, 1, 0, 0, 0, 0, 16'h0, 0, 0, 16'h0, 0);

        // Reset in EXEC discards the instruction; rd reads back as cleared.
        loadReg(2, 16'hAAAA);
        resetInExec(2'd0, 2, 2, 2);
        applyStimulus(2'd3, 3, 2, 2, 0, 0, 16'h0, 0, 0, 16'h0, 0);

        // Randomized traffic.
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 1) == 1)
                loadReg(int'($urandom_range(0, NREGS - 1)), 16'($urandom));
            applyStimulus(2'($urandom_range(0, 3)),
                          int'($urandom_range(0, NREGS - 1)),
                          int'($urandom_range(0, NREGS - 1)),
                          int'($urandom_range(0, NREGS - 1)),
                          bit'($urandom_range(0, 1)),
                          int'($urandom_range(0, NREGS - 1)), 16'($urandom),
                          bit'($urandom_range(0, 1)),
                          int'($urandom_range(0, NREGS - 1)), 16'($urandom),
                          int'($urandom_range(0, 3)));
        end

        repeat (2) @(posedge clk);
        checkOutput("scoreboard_drained", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_alu_sequencer
